// File: rtl/debounce_multi.sv
// debounce_multi: W independent switch debouncers sharing one tick prescaler.
// Each channel has a 2-flop synchroniser and a stability counter. The channel's
// debounced level flips only after K consecutive prescaler ticks in which the
// synchronised input disagreed with the current level. When a channel flips it
// emits a one-cycle rise or fall strobe. any_edge is the OR of every strobe and
// is registered in the same cycle as the strobes.
module debounce_multi #(
  parameter int             W    = 4,
  parameter int             N    = 19,
  parameter int             K    = 3,
  parameter logic [W-1:0]   INIT = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw,
  output logic [W-1:0] db,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall,
  output logic         any_edge
);

  // The counter holds 0..K-1, so clog2(K+1) bits are enough for any K >= 1.
  localparam int            CW       = $clog2(K + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  logic [N-1:0]  q_q, q_d;
  logic          tick;
  logic [W-1:0]  s1_q, s2_q;
  logic [CW-1:0] cnt_q [W];
  logic [CW-1:0] cnt_d [W];
  logic [W-1:0]  db_q, db_d;
  logic [W-1:0]  rise_q, rise_d;
  logic [W-1:0]  fall_q, fall_d;
  logic          any_q, any_d;

  // Free-running prescaler. tick is high for the single cycle in which q is all ones.
  always_comb begin
    q_d  = q_q + N'(1);
    tick = &q_q;
  end

  // Per-channel qualification. A match with the current level clears the count,
  // so any glitch back to that level restarts qualification.
  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]   = s2_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  // Prescaler, synchroniser, counter and output registers. Async reset returns
  // every channel to INIT without generating a strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      s1_q   <= INIT;
      s2_q   <= INIT;
      db_q   <= INIT;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      q_q    <= q_d;
      s1_q   <= sw;
      s2_q   <= s1_q;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign db       = db_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign any_edge = any_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi with W=2, N=3 (tick on cycles 7, 15, 23, ... after
// reset release) and three configurations:
//   a: K=3, INIT=00   b: K=3, INIT=11   c: K=1, INIT=11
// Cycle numbering: cyc is the index of the posedge since reset release, where 0
// is the first posedge with reset low. Outputs are sampled on the following
// negedge. Driving sw on the negedge after edge c makes s2 valid for edge c+3.
// Expected strobe records are packed as {cyc[31:0], rise, fall, db}.
module tb_debounce_multi;

  localparam int W  = 2;
  localparam int N  = 3;
  localparam int EW = 38;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sw_a = 2'b00, sw_b = 2'b11, sw_c = 2'b11;
  logic [W-1:0] db_a, rise_a, fall_a, db_b, rise_b, fall_b, db_c, rise_c, fall_c;
  logic         any_edge_a, any_edge_b, any_edge_c;

  int cyc = -1;
  int vectors = 0;
  int miscompares = 0;

  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];
  logic [EW-1:0] exp_c_q[$];

  debounce_multi #(.W(W), .N(N), .K(3), .INIT(2'b00)) dut_a (
    .clk(clk), .reset(reset), .sw(sw_a), .db(db_a),
    .rise(rise_a), .fall(fall_a), .any_edge(any_edge_a)
  );

  debounce_multi #(.W(W), .N(N), .K(3), .INIT(2'b11)) dut_b (
    .clk(clk), .reset(reset), .sw(sw_b), .db(db_b),
    .rise(rise_b), .fall(fall_b), .any_edge(any_edge_b)
  );

  debounce_multi #(.W(W), .N(N), .K(1), .INIT(2'b11)) dut_c (
    .clk(clk), .reset(reset), .sw(sw_c), .db(db_c),
    .rise(rise_c), .fall(fall_c), .any_edge(any_edge_c)
  );

  // Clock and reset-relative cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= -1;
    else       cyc <= cyc + 1;
  end

  // Watchdog: stop with a failure line if the run stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cyc=%0d, required finish before 100000 time units", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_cyc(input int c);
    while (cyc != c) @(negedge clk);
  endtask

  // Assert reset, check reset values on all instances, release on a negedge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("a_reset_state", {db_a, rise_a, fall_a, any_edge_a}, {2'b00, 2'b00, 2'b00, 1'b0});
    check("b_reset_state", {db_b, rise_b, fall_b, any_edge_b}, {2'b11, 2'b00, 2'b00, 1'b0});
    check("c_reset_state", {db_c, rise_c, fall_c, any_edge_c}, {2'b11, 2'b00, 2'b00, 1'b0});
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitors: every strobe cycle pops one expected record.
  always @(negedge clk) begin
    if (!reset && ((rise_a | fall_a) != 2'b00 || any_edge_a)) begin
      if (exp_a_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL a_unexpected_strobe: got rise=%b fall=%b any=%b at cyc=%0d, expected none",
                 rise_a, fall_a, any_edge_a, cyc);
      end else begin
        check("a_strobe", {32'(cyc), rise_a, fall_a, db_a}, exp_a_q.pop_front());
        check("a_any_edge", any_edge_a, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ((rise_b | fall_b) != 2'b00 || any_edge_b)) begin
      if (exp_b_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b_unexpected_strobe: got rise=%b fall=%b any=%b at cyc=%0d, expected none",
                 rise_b, fall_b, any_edge_b, cyc);
      end else begin
        check("b_strobe", {32'(cyc), rise_b, fall_b, db_b}, exp_b_q.pop_front());
        check("b_any_edge", any_edge_b, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ((rise_c | fall_c) != 2'b00 || any_edge_c)) begin
      if (exp_c_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL c_unexpected_strobe: got rise=%b fall=%b any=%b at cyc=%0d, expected none",
                 rise_c, fall_c, any_edge_c, cyc);
      end else begin
        check("c_strobe", {32'(cyc), rise_c, fall_c, db_c}, exp_c_q.pop_front());
        check("c_any_edge", any_edge_c, 1);
      end
    end
  end

  // Directed stimulus.
  initial begin
    #3;
    do_reset();

    // Clean press on ch0 after edge 0: usable from 3, ticks 7, 15, flip on 23.
    at_cyc(0);
    sw_a = 2'b01;
    exp_a_q.push_back({32'd23, 2'b01, 2'b00, 2'b01});
    at_cyc(40);
    check("press_db", db_a, 2'b01);

    // Release after edge 40 with a one-cycle return to 1 after edge 50.
    // Tick 47 counts 1, the glitch clears on edge 53, then 55, 63, flip on 71.
    sw_a = 2'b00;
    at_cyc(50);
    sw_a = 2'b01;
    at_cyc(51);
    sw_a = 2'b00;
    exp_a_q.push_back({32'd71, 2'b00, 2'b01, 2'b00});
    at_cyc(66);
    check("release_glitch_holds_db", db_a, 2'b01);
    at_cyc(75);
    check("release_db", db_a, 2'b00);

    // Bounce: ch0 toggles every 3 cycles from edge 80 to 119, then settles at 1
    // after edge 122: ticks 127, 135, flip on 143.
    for (int j = 0; j < 14; j++) begin
      at_cyc(80 + 3 * j);
      sw_a[0] = (j % 2 == 0) ? 1'b1 : 1'b0;
    end
    at_cyc(122);
    sw_a[0] = 1'b1;
    exp_a_q.push_back({32'd143, 2'b01, 2'b00, 2'b01});
    at_cyc(140);
    check("bounce_db_still_low", db_a, 2'b00);
    at_cyc(150);
    check("bounce_settled_db", db_a, 2'b01);

    // Simultaneous press on both channels after edge 2: flip together on 23.
    sw_a = 2'b00;
    do_reset();
    at_cyc(2);
    sw_a = 2'b11;
    exp_a_q.push_back({32'd23, 2'b11, 2'b00, 2'b11});
    at_cyc(24);
    check("simul_after_strobe", {db_a, rise_a, fall_a, any_edge_a}, {2'b11, 2'b00, 2'b00, 1'b0});

    // Reset from db=11 back to INIT, with ch0 already high at release: flip 23.
    at_cyc(30);
    sw_a = 2'b01;
    do_reset();
    exp_a_q.push_back({32'd23, 2'b01, 2'b00, 2'b01});

    // ch1 starts qualifying after edge 30 (ticks 39, 47). K=1 instance c drops
    // ch0 after edge 30: usable from 33, flip on the first tick, 39.
    at_cyc(30);
    sw_a = 2'b11;
    sw_c = 2'b10;
    exp_c_q.push_back({32'd39, 2'b00, 2'b01, 2'b10});
    at_cyc(48);
    check("midqual_db_before_reset", db_a, 2'b01);
    check("k1_db_after_flip", db_c, 2'b10);

    // Async reset mid-qualification, then release with only ch1 high: flip 23.
    at_cyc(50);
    #2;
    sw_a = 2'b10;
    do_reset();
    sw_c = 2'b11;
    exp_a_q.push_back({32'd23, 2'b10, 2'b00, 2'b10});
    at_cyc(22);
    check("post_reset_db_before_flip", db_a, 2'b00);
    at_cyc(60);
    check("final_db_a", db_a, 2'b10);
    check("final_db_b", db_b, 2'b11);
    check("final_db_c", db_c, 2'b11);
    check("a_queue_empty", 64'(exp_a_q.size()), 64'd0);
    check("b_queue_empty", 64'(exp_b_q.size()), 64'd0);
    check("c_queue_empty", 64'(exp_c_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
